count_sequencer: RTL and testbench

COUNT_SEQUENCER -- requirements
Module: count_sequencer

---
 rtl/count_sequencer_if.sv | 24 ++
 rtl/count_sequencer.sv | 104 ++++++++++
 tb/tb_count_sequencer.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/count_sequencer_if.sv
// Command/status bundle for count_sequencer: the controller drives commands
// and the terminal value, and the sequencer returns count, busy and done.
interface count_sequencer_if #(
    parameter int unsigned WIDTH = 4
);
    logic             start;
    logic             stop;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             periodic;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;

    modport master (
        output start, stop, load, load_val, periodic,
        input  count, busy, done
    );

    modport slave (
        input  start, stop, load, load_val, periodic,
        output count, busy, done
    );
endinterface

// File: rtl/count_sequencer.sv
// Start/stop/hold counter that runs up to a loadable terminal value, one-shot or periodic.
// Define COUNT_SEQUENCER_PRESCALE_EN to advance the count only once every PRESCALE cycles.
module count_sequencer #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst,
    count_sequencer_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StRun, StHold} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] tc_q;
    logic             done_q;
    logic             busy_q;
    logic             step;
    logic             term;
    logic             enter_run;

    // Entering RUN from IDLE or HOLD (stop always takes precedence over start)
    assign enter_run = (state_q != StRun) && !bus.stop && bus.start;

`ifdef COUNT_SEQUENCER_PRESCALE_EN
    localparam logic [7:0] PreLast = 8'(PRESCALE - 1);

    logic [7:0] pre_q;

    assign step = (pre_q == PreLast);

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q <= 8'd0;
        end else if (enter_run) begin
            pre_q <= 8'd0;
        end else if (state_q == StRun) begin
            pre_q <= step ? 8'd0 : pre_q + 8'd1;
        end
    end
`else
    logic unused_prescale;

    assign unused_prescale = ^PRESCALE;
    assign step            = 1'b1;
`endif

    assign term = (state_q == StRun) && step && (count_q == tc_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            count_q <= '0;
            tc_q    <= '1;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (enter_run) begin
                        state_q <= StRun;
                        busy_q  <= 1'b1;
                    end else if (!bus.stop && bus.load) begin
                        tc_q    <= bus.load_val;
                        count_q <= '0;
                    end
                end
                StRun: begin
                    // A terminal match beats a coincident stop and always ends a stopped run
                    if (term) begin
                        count_q <= '0;
                        done_q  <= 1'b1;
                        if (!bus.periodic || bus.stop) begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                        end
                    end else if (bus.stop) begin
                        state_q <= StHold;
                    end else if (step) begin
                        count_q <= count_q + 1'b1;
                    end
                end
                StHold: begin
                    if (bus.stop) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        count_q <= '0;
                    end else if (bus.start) begin
                        state_q <= StRun;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.count = count_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
endmodule

// File: tb/tb_count_sequencer.sv
// Directed bench for count_sequencer: a rule-level model checked every cycle,
// plus literal expectations at key points of each scenario.
module tb_count_sequencer;
    localparam int unsigned W  = 4;
    localparam int unsigned PS = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    count_sequencer_if #(.WIDTH(W)) bus ();

    count_sequencer #(
        .WIDTH   (W),
        .PRESCALE(PS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d required %0d", name, $time, got, exp);
        end
    endtask

    // Model: 0 idle, 1 running, 2 held
    int m_st    = 0;
    int m_count = 0;
    int m_tc    = 15;
    int m_done  = 0;
    int m_pre   = 0;
    bit m_valid = 1'b0;

    always @(posedge clk) begin
        int  prev_st;
        bit  stp;
        prev_st = m_st;
        if (rst) begin
            m_st = 0; m_count = 0; m_tc = 2**W - 1; m_done = 0; m_pre = 0;
            m_valid = 1'b1;
        end else begin
            m_done = 0;
            if (prev_st == 0) begin
                if (bus.stop) begin
                end else if (bus.start) begin
                    m_st = 1; m_pre = 0;
                end else if (bus.load) begin
                    m_tc = int'(bus.load_val); m_count = 0;
                end
            end else if (prev_st == 1) begin
`ifdef COUNT_SEQUENCER_PRESCALE_EN
                stp   = (m_pre == PS - 1);
                m_pre = (m_pre + 1) % PS;
`else
                stp = 1'b1;
`endif
                if (stp && m_count == m_tc) begin
                    m_count = 0; m_done = 1;
                    if (!bus.periodic || bus.stop) m_st = 0;
                end else if (bus.stop) begin
                    m_st = 2;
                end else if (stp) begin
                    m_count = m_count + 1;
                end
            end else begin
                if (bus.stop) begin
                    m_st = 0; m_count = 0;
                end else if (bus.start) begin
                    m_st = 1; m_pre = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_count", 32'(bus.count), 32'(m_count));
            check("model_busy", 32'(bus.busy), 32'(m_st != 0));
            check("model_done", 32'(bus.done), 32'(m_done));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
    endtask

    task automatic do_load(input int v);
        bus.load     = 1'b1;
        bus.load_val = W'(v);
        tick(1);
        bus.load     = 1'b0;
    endtask

    task automatic lit(input string name, input int c, input int b, input int d);
        check({name, "_count"}, 32'(bus.count), 32'(c));
        check({name, "_busy"}, 32'(bus.busy), 32'(b));
        check({name, "_done"}, 32'(bus.done), 32'(d));
    endtask

    initial begin
        bus.start = 1'b0; bus.stop = 1'b0; bus.load = 1'b0;
        bus.load_val = '0; bus.periodic = 1'b0;
        tick(2);
        rst = 1'b0;
        lit("reset", 0, 0, 0);
`ifdef COUNT_SEQUENCER_PRESCALE_EN
        pulse_start();
        tick(3);
        lit("pre_c0", 0, 1, 0);
        tick(1);
        lit("pre_c1", 1, 1, 0);
        tick(4);
        lit("pre_c2", 2, 1, 0);
        tick(8);
`else
        // One-shot to the reset terminal value of 15
        pulse_start();
        tick(1);
        lit("oneshot_first", 1, 1, 0);
        tick(14);
        lit("oneshot_15", 15, 1, 0);
        tick(1);
        lit("oneshot_term", 0, 0, 1);
        tick(1);
        lit("oneshot_after", 0, 0, 0);

        // Periodic with tc = 5
        do_load(5);
        bus.periodic = 1'b1;
        pulse_start();
        tick(5);
        lit("per_5", 5, 1, 0);
        tick(1);
        lit("per_wrap1", 0, 1, 1);
        tick(6);
        lit("per_wrap2", 0, 1, 1);
        tick(3);
        lit("per_3", 3, 1, 0);

        // Pause at 3, resume
        bus.stop = 1'b1;
        tick(1);
        bus.stop = 1'b0;
        tick(4);
        lit("hold_3", 3, 1, 0);
        pulse_start();
        lit("resume_edge", 3, 1, 0);
        tick(1);
        lit("resume_4", 4, 1, 0);

        // Stop into HOLD, stop again aborts
        bus.stop = 1'b1;
        tick(2);
        bus.stop = 1'b0;
        lit("abort", 0, 0, 0);

        // Load ignored while running, then reset mid-run
        do_load(15);
        bus.periodic = 1'b0;
        pulse_start();
        tick(7);
        do_load(2);
        lit("load_ignored", 8, 1, 0);
        tick(1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        lit("rst_midrun", 0, 0, 0);
        pulse_start();
        tick(15);
        lit("tc_is_15", 15, 1, 0);
        tick(1);
        lit("tc_15_term", 0, 0, 1);

        // Stop coincident with terminal match
        do_load(5);
        bus.periodic = 1'b1;
        pulse_start();
        tick(5);
        bus.stop = 1'b1;
        tick(1);
        bus.stop = 1'b0;
        lit("stop_at_term", 0, 0, 1);

        // tc = 0 periodic: done every step
        do_load(0);
        pulse_start();
        tick(1);
        lit("tc0_a", 0, 1, 1);
        tick(1);
        lit("tc0_b", 0, 1, 1);
        bus.stop = 1'b1;
        tick(1);
        bus.stop = 1'b0;

        // start+stop in IDLE stays idle; start+stop in RUN holds
        do_load(9);
        bus.start = 1'b1; bus.stop = 1'b1;
        tick(1);
        lit("idle_ss", 0, 0, 0);
        bus.stop = 1'b0;
        tick(1);
        bus.start = 1'b0;
        tick(2);
        bus.start = 1'b1; bus.stop = 1'b1;
        tick(1);
        bus.start = 1'b0; bus.stop = 1'b0;
        tick(2);
        lit("run_ss_hold", 2, 1, 0);

        // Reset coincident with terminal match
        pulse_start();
        tick(7);
        lit("pre_rst_9", 9, 1, 0);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        lit("rst_at_term", 0, 0, 0);
        tick(2);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
